cpu_oci_dct_packer: RTL and testbench

Producer side of the OCI direct-branch compressed trace (DCT) frame interface. Packs 2-bit branch codes from the CPU trace path into 30-bit frames of up to 15 codes, each with a 4-bit code count. Presents frames through a single-entry valid/ready output register to the trace FIFO and simulation monitor. Also sequences an end-of-test drain and reports it on `test_ending` and `test_has_ended`.

---
 rtl/cpu_oci_dct_packer.sv | 139 +++++++++++++
 tb/tb_cpu_oci_dct_packer.sv | 500 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_oci_dct_packer.sv
// rtl/cpu_oci_dct_packer.sv - packs 2-bit branch codes into DCT frames behind a one-entry output register
module cpu_oci_dct_packer #(
    parameter int MAX_CODES = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        code_valid,
    input  logic [1:0]  code,
    output logic        code_ready,
    input  logic        flush,
    input  logic        end_req,
    output logic [29:0] dct_buffer,
    output logic [3:0]  dct_count,
    output logic        dct_valid,
    input  logic        dct_ready,
    output logic        test_ending,
    output logic        test_has_ended
);

    localparam logic [3:0] MAX_C = 4'(MAX_CODES);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [29:0] acc_q, acc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        flush_pend_q, flush_pend_d;
    logic [29:0] buf_q, buf_d;
    logic [3:0]  count_q, count_d;
    logic        valid_q, valid_d;
    logic        ending_q, ending_d;
    logic        ended_q, ended_d;

    logic        accept;
    logic        flush_live;
    logic        out_free;
    logic        close_frame;
    logic [3:0]  cnt_next;
    logic [29:0] acc_next;

    // Decoded from registered state only, so no input reaches it combinationally.
    assign code_ready = (state_q == ST_RUN) && (cnt_q < MAX_C);

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q;
        buf_d        = buf_q;
        count_d      = count_q;
        valid_d      = valid_q;

        accept     = code_valid && code_ready;
        flush_live = flush && (state_q == ST_RUN);
        out_free   = !valid_q || dct_ready;
        cnt_next   = cnt_q + {3'b000, accept};
        acc_next   = acc_q;
        if (accept) begin
            acc_next = acc_q | ({28'd0, code} << {cnt_q, 1'b0});
        end

        close_frame = (cnt_next == MAX_C) ||
                      ((cnt_next != 4'd0) &&
                       (flush_pend_q || flush_live || (state_q == ST_DRAIN)));

        if (close_frame && out_free) begin
            buf_d        = acc_next;
            count_d      = cnt_next;
            valid_d      = 1'b1;
            acc_d        = '0;
            cnt_d        = '0;
            flush_pend_d = 1'b0;
        end else begin
            if (valid_q && dct_ready) begin
                valid_d = 1'b0;
            end
            acc_d = acc_next;
            cnt_d = cnt_next;
            // A flush that cannot close now is remembered; an empty flush is dropped.
            if (flush_live && (cnt_next != 4'd0)) begin
                flush_pend_d = 1'b1;
            end
        end

        case (state_q)
            ST_RUN: begin
                if (end_req) begin
                    // Nothing buffered at all: finish straight away.
                    state_d = ((cnt_next == 4'd0) && !valid_d) ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((cnt_q == 4'd0) && out_free) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_RUN;
        endcase

        ending_d = (state_d == ST_DRAIN);
        ended_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_RUN;
            acc_q        <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            buf_q        <= '0;
            count_q      <= '0;
            valid_q      <= 1'b0;
            ending_q     <= 1'b0;
            ended_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            buf_q        <= buf_d;
            count_q      <= count_d;
            valid_q      <= valid_d;
            ending_q     <= ending_d;
            ended_q      <= ended_d;
        end
    end

    assign dct_buffer     = buf_q;
    assign dct_count      = count_q;
    assign dct_valid      = valid_q;
    assign test_ending    = ending_q;
    assign test_has_ended = ended_q;

endmodule

// File: tb/tb_cpu_oci_dct_packer.sv
// tb/tb_cpu_oci_dct_packer.sv - self-checking bench for cpu_oci_dct_packer
module tb_cpu_oci_dct_packer;

    localparam int MAXC = 15;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        code_valid = 1'b0;
    logic [1:0]  code = 2'd0;
    logic        flush = 1'b0;
    logic        end_req = 1'b0;
    logic        dct_ready = 1'b0;
    logic        code_ready;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        dct_valid;
    logic        test_ending;
    logic        test_has_ended;

    int tests = 0;
    int fails = 0;

    logic [1:0]  acc_log[$];
    logic [33:0] frames[$];
    bit          mon_en = 1'b0;

    cpu_oci_dct_packer #(.MAX_CODES(MAXC)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .code_valid     (code_valid),
        .code           (code),
        .code_ready     (code_ready),
        .flush          (flush),
        .end_req        (end_req),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .dct_valid      (dct_valid),
        .dct_ready      (dct_ready),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mon_en && reset_n && dct_valid && dct_ready) begin
            frames.push_back({dct_count, dct_buffer});
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [29:0] pack(input logic [1:0] q[$], input int start, input int n);
        logic [29:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[2*i +: 2] = q[start + i];
        return r;
    endfunction

    task automatic step();
        if (code_valid && code_ready) acc_log.push_back(code);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        code_valid = 1'b0;
        flush      = 1'b0;
        end_req    = 1'b0;
        dct_ready  = 1'b0;
        reset_n    = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        acc_log.delete();
        frames.delete();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        tests++;
        if ({dct_valid, dct_count, dct_buffer, test_ending, test_has_ended} !== 36'd0) begin
            fails++;
            $display("FAIL reset_outputs: valid=%0b count=%0d buf=%h ending=%0b ended=%0b, required all 0",
                     dct_valid, dct_count, dct_buffer, test_ending, test_has_ended);
        end
        tests++;
        if (code_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_code_ready: got %0b, required 1", code_ready);
        end
        do_reset();
        step();
        tests++;
        if (code_ready !== 1'b1 || dct_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: code_ready=%0b valid=%0b, required 1/0", code_ready, dct_valid);
        end
    endtask

    task automatic test_full_frame();
        logic [1:0] sent[$];
        do_reset();
        dct_ready = 1'b1;
        for (int i = 0; i < MAXC; i++) begin
            code_valid = 1'b1;
            code = 2'(i % 4);
            sent.push_back(code);
            step();
            if (i < MAXC - 1) begin
                tests++;
                if (dct_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL full_early_valid: cycle %0d valid=%0b, required 0", i, dct_valid);
                end
            end
        end
        code_valid = 1'b0;
        tests++;
        if (dct_valid !== 1'b1 || dct_count !== 4'(MAXC)) begin
            fails++;
            $display("FAIL full_frame: valid=%0b count=%0d, required 1/%0d", dct_valid, dct_count, MAXC);
        end
        for (int k = 0; k < MAXC; k++) begin
            tests++;
            if (dct_buffer[2*k +: 2] !== 2'(k % 4)) begin
                fails++;
                $display("FAIL full_code%0d: got %0d, required %0d", k, dct_buffer[2*k +: 2], k % 4);
            end
        end
        tests++;
        if (dct_buffer !== pack(sent, 0, MAXC)) begin
            fails++;
            $display("FAIL full_buffer: got %h, required %h", dct_buffer, pack(sent, 0, MAXC));
        end
        step();
        tests++;
        if (dct_valid !== 1'b0) begin
            fails++;
            $display("FAIL full_one_cycle: valid=%0b, required 0", dct_valid);
        end
    endtask

    task automatic test_partial_flush();
        do_reset();
        dct_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            code_valid = 1'b1;
            code = 2'b11;
            step();
        end
        code_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        tests++;
        if (dct_valid !== 1'b1 || dct_count !== 4'd3 || dct_buffer !== 30'h0000003F) begin
            fails++;
            $display("FAIL partial_flush: valid=%0b count=%0d buf=%h, required 1/3/0000003f",
                     dct_valid, dct_count, dct_buffer);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        tests++;
        if (dct_valid !== 1'b0) begin
            fails++;
            $display("FAIL empty_flush_a: valid=%0b, required 0", dct_valid);
        end
        step();
        tests++;
        if (dct_valid !== 1'b0) begin
            fails++;
            $display("FAIL empty_flush_b: valid=%0b, required 0", dct_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] sent[$];
        int accepted;
        do_reset();
        dct_ready = 1'b0;
        accepted = 0;
        for (int i = 0; i < 2 * MAXC; i++) begin
            code_valid = 1'b1;
            code = 2'($urandom);
            if (code_ready) begin
                sent.push_back(code);
                accepted++;
            end
            step();
        end
        tests++;
        if (accepted !== 2 * MAXC) begin
            fails++;
            $display("FAIL bp_accepted: got %0d, required %0d", accepted, 2 * MAXC);
        end
        for (int i = 0; i < 3; i++) begin
            code_valid = 1'b1;
            code = 2'($urandom);
            tests++;
            if (code_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_ready_low: cycle %0d code_ready=%0b, required 0", i, code_ready);
            end
            step();
            tests++;
            if (dct_valid !== 1'b1 || dct_count !== 4'(MAXC) || dct_buffer !== pack(sent, 0, MAXC)) begin
                fails++;
                $display("FAIL bp_first_stable: valid=%0b count=%0d buf=%h, required 1/%0d/%h",
                         dct_valid, dct_count, dct_buffer, MAXC, pack(sent, 0, MAXC));
            end
        end
        code_valid = 1'b0;
        dct_ready = 1'b1;
        step();
        dct_ready = 1'b0;
        tests++;
        if (dct_valid !== 1'b1 || dct_count !== 4'(MAXC) || dct_buffer !== pack(sent, MAXC, MAXC)) begin
            fails++;
            $display("FAIL bp_second: valid=%0b count=%0d buf=%h, required 1/%0d/%h",
                     dct_valid, dct_count, dct_buffer, MAXC, pack(sent, MAXC, MAXC));
        end
        tests++;
        if (code_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_ready_back: code_ready=%0b, required 1", code_ready);
        end
        dct_ready = 1'b1;
        step();
    endtask

    task automatic test_simultaneous();
        logic [1:0] sent[$];
        do_reset();
        dct_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            code_valid = 1'b1;
            code = 2'($urandom);
            flush = (i == 13);
            sent.push_back(code);
            step();
        end
        code_valid = 1'b0;
        flush = 1'b0;
        tests++;
        if (dct_valid !== 1'b1 || dct_count !== 4'd14 || dct_buffer !== pack(sent, 0, 14)) begin
            fails++;
            $display("FAIL simul_flush: valid=%0b count=%0d buf=%h, required 1/14/%h",
                     dct_valid, dct_count, dct_buffer, pack(sent, 0, 14));
        end
        step();
        tests++;
        if (dct_valid !== 1'b0) begin
            fails++;
            $display("FAIL simul_single: valid=%0b, required 0", dct_valid);
        end
    endtask

    task automatic test_end_drain();
        logic [1:0] sent[$];
        do_reset();
        dct_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            code_valid = 1'b1;
            code = 2'($urandom);
            sent.push_back(code);
            step();
        end
        code_valid = 1'b0;
        end_req = 1'b1;
        step();
        end_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (test_ending !== 1'b1 || code_ready !== 1'b0 || test_has_ended !== 1'b0) begin
                fails++;
                $display("FAIL drain_state: cycle %0d ending=%0b ready=%0b ended=%0b, required 1/0/0",
                         i, test_ending, code_ready, test_has_ended);
            end
            step();
        end
        tests++;
        if (dct_valid !== 1'b1 || dct_count !== 4'd5 || dct_buffer !== pack(sent, 0, 5)) begin
            fails++;
            $display("FAIL drain_frame: valid=%0b count=%0d buf=%h, required 1/5/%h",
                     dct_valid, dct_count, dct_buffer, pack(sent, 0, 5));
        end
        dct_ready = 1'b1;
        step();
        tests++;
        if (test_has_ended !== 1'b1 || test_ending !== 1'b0 || dct_valid !== 1'b0) begin
            fails++;
            $display("FAIL drain_done: ended=%0b ending=%0b valid=%0b, required 1/0/0",
                     test_has_ended, test_ending, dct_valid);
        end
        code_valid = 1'b1;
        flush = 1'b1;
        end_req = 1'b1;
        step();
        step();
        code_valid = 1'b0;
        flush = 1'b0;
        end_req = 1'b0;
        tests++;
        if (test_has_ended !== 1'b1 || code_ready !== 1'b0 || dct_valid !== 1'b0 || test_ending !== 1'b0) begin
            fails++;
            $display("FAIL done_sticky: ended=%0b ready=%0b valid=%0b ending=%0b, required 1/0/0/0",
                     test_has_ended, code_ready, dct_valid, test_ending);
        end
        do_reset();
        end_req = 1'b1;
        step();
        end_req = 1'b0;
        tests++;
        if (test_has_ended !== 1'b1) begin
            fails++;
            $display("FAIL end_empty: ended=%0b, required 1", test_has_ended);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] sent[$];
        do_reset();
        dct_ready = 1'b0;
        for (int i = 0; i < MAXC + 7; i++) begin
            code_valid = 1'b1;
            code = 2'($urandom);
            step();
        end
        code_valid = 1'b0;
        tests++;
        if (dct_valid !== 1'b1) begin
            fails++;
            $display("FAIL mid_setup: valid=%0b, required 1", dct_valid);
        end
        #2;
        reset_n = 1'b0;
        #1;
        tests++;
        if ({dct_valid, dct_count, dct_buffer, test_ending, test_has_ended} !== 36'd0 || code_ready !== 1'b1) begin
            fails++;
            $display("FAIL mid_async_reset: valid=%0b count=%0d buf=%h ready=%0b, required 0/0/0/1",
                     dct_valid, dct_count, dct_buffer, code_ready);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        dct_ready = 1'b1;
        tests++;
        if (code_ready !== 1'b1) begin
            fails++;
            $display("FAIL mid_ready: code_ready=%0b, required 1", code_ready);
        end
        for (int i = 0; i < 3; i++) begin
            code_valid = 1'b1;
            code = 2'($urandom);
            flush = (i == 2);
            sent.push_back(code);
            step();
        end
        code_valid = 1'b0;
        flush = 1'b0;
        tests++;
        if (dct_valid !== 1'b1 || dct_count !== 4'd3 || dct_buffer !== pack(sent, 0, 3)) begin
            fails++;
            $display("FAIL mid_new_frame: valid=%0b count=%0d buf=%h, required 1/3/%h",
                     dct_valid, dct_count, dct_buffer, pack(sent, 0, 3));
        end
    endtask

    task automatic test_random_ready();
        logic [1:0]  cur[$];
        logic        exp_v;
        logic [3:0]  exp_cnt;
        logic [29:0] exp_buf;
        do_reset();
        dct_ready = 1'b1;
        exp_cnt = '0;
        exp_buf = '0;
        for (int c = 0; c < 300; c++) begin
            code_valid = ($urandom % 4) != 0;
            code = 2'($urandom);
            flush = ($urandom % 8) == 0;
            tests++;
            if (code_ready !== 1'b1) begin
                fails++;
                $display("FAIL rr_code_ready: cycle %0d got %0b, required 1", c, code_ready);
            end
            if (code_valid) cur.push_back(code);
            exp_v = 1'b0;
            if (cur.size() == MAXC || (flush && cur.size() > 0)) begin
                exp_v = 1'b1;
                exp_cnt = 4'(cur.size());
                exp_buf = pack(cur, 0, cur.size());
                cur.delete();
            end
            step();
            tests++;
            if (dct_valid !== exp_v) begin
                fails++;
                $display("FAIL rr_valid: cycle %0d got %0b, required %0b", c, dct_valid, exp_v);
            end else if (exp_v) begin
                tests++;
                if (dct_count !== exp_cnt || dct_buffer !== exp_buf) begin
                    fails++;
                    $display("FAIL rr_frame: cycle %0d count=%0d buf=%h, required %0d/%h",
                             c, dct_count, dct_buffer, exp_cnt, exp_buf);
                end
            end
        end
        code_valid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic test_random_backpressure();
        logic [1:0]  got[$];
        logic        hold;
        logic [33:0] prev;
        bool_t_dummy: begin end
        do_reset();
        mon_en = 1'b1;
        for (int c = 0; c < 400; c++) begin
            code_valid = ($urandom % 3) != 0;
            code = 2'($urandom);
            flush = ($urandom % 16) == 0;
            dct_ready = ($urandom % 2) == 0;
            hold = dct_valid && !dct_ready;
            prev = {dct_count, dct_buffer};
            step();
            if (hold) begin
                tests++;
                if (dct_valid !== 1'b1 || {dct_count, dct_buffer} !== prev) begin
                    fails++;
                    $display("FAIL rb_hold: cycle %0d valid=%0b frame=%h, required 1/%h",
                             c, dct_valid, {dct_count, dct_buffer}, prev);
                end
            end
        end
        code_valid = 1'b0;
        dct_ready = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        dct_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        mon_en = 1'b0;
        foreach (frames[f]) begin
            logic [3:0]  n;
            logic [29:0] b;
            n = frames[f][33:30];
            b = frames[f][29:0];
            tests++;
            if (n == 4'd0 || n > 4'(MAXC) || (n < 4'd15 && (b >> (2 * n)) != 30'd0)) begin
                fails++;
                $display("FAIL rb_frame_shape: frame %0d count=%0d buf=%h", f, n, b);
            end
            for (int k = 0; k < int'(n); k++) got.push_back(b[2*k +: 2]);
        end
        tests++;
        if (got.size() != acc_log.size()) begin
            fails++;
            $display("FAIL rb_code_total: got %0d codes, required %0d", got.size(), acc_log.size());
        end else begin
            int bad;
            bad = 0;
            foreach (got[i]) if (got[i] !== acc_log[i]) bad++;
            tests++;
            if (bad != 0) begin
                fails++;
                $display("FAIL rb_code_order: %0d codes differ, required 0", bad);
            end
        end
        tests++;
        if (dct_valid !== 1'b0) begin
            fails++;
            $display("FAIL rb_drained: valid=%0b, required 0", dct_valid);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_partial_flush();
        test_backpressure();
        test_simultaneous();
        test_end_drain();
        test_reset_mid();
        test_random_ready();
        test_random_backpressure();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
